// File: rtl/psg_write_scheduler.sv
// Timed register-write scheduler for the AY-3-8913 PSG: queues (reg, data, frame-delay)
// commands and replays each as an address-latch / data-write sequence on BDIR/BC1.
module psg_write_scheduler #(
  parameter int DEPTH     = 4,
  parameter int FRAME_DIV = 20000,
  parameter int HOLD      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_reg,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_wait,
  input  logic       flush,
  output logic [7:0] bus_data,
  output logic       bdir,
  output logic       bc1,
  output logic       frame_tick,
  output logic       busy
);

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is combinational and drops while the FIFO is full or flush is high.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ADDR, S_GAP, S_WRITE, S_END
  } state_t;

  state_t state, state_next;

  logic [FW-1:0] fcnt;
  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [3:0]    head_reg, cur_reg;
  logic [7:0]    head_wait, head_data, cur_data, wcnt;
  logic [HW-1:0] hcnt;
  logic          hold_done, flushed;

  // Frame counter runs independently of the write sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (fcnt == FW'(FRAME_DIV - 1));
      fcnt       <= (fcnt == FW'(FRAME_DIV - 1)) ? '0 : fcnt + 1'b1;
    end
  end

  assign full      = (count == (AW + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  // A flush during a sequence leaves 'flushed' set so END never pops a newer command.
  assign pop       = (state == S_END) && !flushed && !empty && !flush;
  assign {head_reg, head_wait, head_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_reg, cmd_wait, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign hold_done = (hcnt == HW'(HOLD - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty && !flush) state_next = (head_wait != 8'd0) ? S_WAIT : S_ADDR;
      S_WAIT: begin
        if (flush) state_next = S_IDLE;
        else if (frame_tick && wcnt == 8'd1) state_next = S_ADDR;
      end
      S_ADDR:  if (hold_done) state_next = S_GAP;
      S_GAP:   state_next = S_WRITE;
      S_WRITE: if (hold_done) state_next = S_END;
      S_END:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hcnt     <= '0;
      wcnt     <= '0;
      cur_reg  <= '0;
      cur_data <= '0;
      flushed  <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == S_ADDR || state == S_WRITE) && !hold_done) hcnt <= hcnt + 1'b1;
      else hcnt <= '0;
      // The head is captured while idle so a flush cannot change an in-flight write.
      if (state == S_IDLE) begin
        wcnt     <= head_wait;
        cur_reg  <= head_reg;
        cur_data <= head_data;
      end else if (state == S_WAIT && frame_tick) begin
        wcnt <= wcnt - 1'b1;
      end
      if (state == S_END) flushed <= 1'b0;
      else if (flush && (state == S_ADDR || state == S_GAP || state == S_WRITE)) flushed <= 1'b1;
    end
  end

  // Bus pins follow the state one cycle later; GAP separates 11 from 10.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bdir     <= 1'b0;
      bc1      <= 1'b0;
      bus_data <= 8'h00;
    end else begin
      bdir <= (state == S_ADDR) || (state == S_WRITE);
      bc1  <= (state == S_ADDR);
      if (state == S_ADDR)       bus_data <= {4'b0000, cur_reg};
      else if (state == S_WRITE) bus_data <= cur_data;
    end
  end

  assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_psg_write_scheduler.sv
// Self-checking bench for psg_write_scheduler: timestamp-based reference model plus
// directed scenarios (single write, frame alignment, FIFO full, flush, async reset).
module tb_psg_write_scheduler;

  localparam int DEPTH     = 4;
  localparam int FRAME_DIV = 8;
  localparam int HOLD      = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_reg = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] cmd_wait = '0;
  logic       flush = 1'b0;
  logic [7:0] bus_data;
  logic       bdir, bc1, frame_tick, busy;

  int checks = 0;
  int errors = 0;

  psg_write_scheduler #(.DEPTH(DEPTH), .FRAME_DIV(FRAME_DIV), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .cmd_wait(cmd_wait), .flush(flush),
    .bus_data(bus_data), .bdir(bdir), .bc1(bc1), .frame_tick(frame_tick), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue entries are {reg, wait, data}. A scheduled write is described only by the
  // cycle its address phase starts (pa); everything else is arithmetic on that.
  logic [19:0] exp_q[$];
  int          mc;
  bit          plan, supp;
  int          pa;
  logic [3:0]  p_reg;
  logic [7:0]  p_data, exp_bd;

  function automatic int addr_start(input int c, input int n);
    int t;
    if (n == 0) return c + 1;
    t = ((c + FRAME_DIV) / FRAME_DIV) * FRAME_DIV;  // first tick cycle after c
    return t + FRAME_DIV * (n - 1) + 1;
  endfunction

  always @(negedge clk) begin
    logic [12:0] exp_v, act_v;
    logic        e_bdir, e_bc1, e_ready, e_tick, e_busy, acc;
    logic [19:0] head;
    act_v = {bdir, bc1, bus_data, frame_tick, busy, cmd_ready};
    if (!rst_n) begin
      exp_q.delete();
      mc = 0; plan = 0; supp = 0; pa = 0; exp_bd = 8'h00;
      exp_v = {2'b00, 8'h00, 1'b0, 1'b0, !flush};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_outputs actual=%h expected=%h", act_v, exp_v);
      end
    end else begin
      e_bdir = 1'b0; e_bc1 = 1'b0;
      if (plan) begin
        if (mc >= pa + 1 && mc <= pa + HOLD) begin
          e_bdir = 1'b1; e_bc1 = 1'b1; exp_bd = {4'h0, p_reg};
        end else if (mc >= pa + HOLD + 2 && mc <= pa + 2 * HOLD + 1) begin
          e_bdir = 1'b1; exp_bd = p_data;
        end
      end
      e_ready = (exp_q.size() < DEPTH) && !flush;
      e_tick  = (mc >= FRAME_DIV) && (mc % FRAME_DIV == 0);
      e_busy  = plan || (exp_q.size() > 0);
      exp_v = {e_bdir, e_bc1, exp_bd, e_tick, e_busy, e_ready};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model cyc=%0d actual=%h expected=%h", mc, act_v, exp_v);
      end
      acc = cmd_valid && e_ready;
      if (plan) begin
        if (flush && mc < pa) plan = 0;
        else if (mc == pa + 2 * HOLD + 1) begin
          plan = 0;
          if (!supp && !flush && exp_q.size() > 0) void'(exp_q.pop_front());
          supp = 0;
        end else if (flush) supp = 1;
      end else if (!flush && exp_q.size() > 0) begin
        head   = exp_q[0];
        p_reg  = head[19:16];
        p_data = head[7:0];
        pa     = addr_start(mc, int'(head[15:8]));
        plan   = 1;
        supp   = 0;
      end
      if (flush) exp_q.delete();
      else if (acc) exp_q.push_back({cmd_reg, cmd_wait, cmd_data});
      mc++;
    end
  end

  // Log of register addresses actually latched on the bus.
  logic [3:0] seen_q[$];
  logic       prev11 = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bdir && bc1 && !prev11) seen_q.push_back(bus_data[3:0]);
    prev11 = rst_n && bdir && bc1;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic [3:0] r, input logic [7:0] d, input logic [7:0] w);
    bit ok;
    ok = 0;
    cmd_valid = 1'b1; cmd_reg = r; cmd_data = d; cmd_wait = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_timeout reg=%0h not accepted", r);
    end
  endtask

  task automatic wait_idle(input int n);
    bit idle;
    idle = 0;
    for (int i = 0; i < n && !idle; i++) begin
      @(negedge clk); idle = !busy;
    end
    next_cycle();
    chk("wait_idle", {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_addr(input int n, output bit seen);
    seen = 0;
    for (int i = 0; i < n && !seen; i++) begin
      @(negedge clk); seen = bdir && bc1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_addr no address phase within %0d cycles", n);
    end
  endtask

  logic [1:0] sw_pair [8] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00};
  logic [7:0] sw_data [8] = '{8'h00, 8'h00, 8'h07, 8'h07, 8'h07, 8'h38, 8'h38, 8'h38};
  logic       sw_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // ---------------- scenarios ----------------
  initial begin
    int ticks, first_tick, second_tick, last_tick, found_at, n10, n11, nacc;
    bit seen, accepted;
    logic [1:0] prev_pair;
    logic       prev_ready;
    logic [3:0] acc_regs[$];

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    next_cycle();

    // Single write, wait 0: exact pin sequence from the accepting edge.
    push_cmd(4'h7, 8'h38, 8'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("single_pair_%0d", i), {30'd0, bdir, bc1}, {30'd0, sw_pair[i]});
      chk($sformatf("single_data_%0d", i), {24'd0, bus_data}, {24'd0, sw_data[i]});
      chk($sformatf("single_busy_%0d", i), {31'd0, busy}, {31'd0, sw_busy[i]});
    end
    next_cycle();

    // Frame alignment: wait=3 pushed mid-frame.
    repeat ($urandom_range(1, 7)) next_cycle();
    push_cmd(4'h1, 8'hAA, 8'd3);
    ticks = 0; first_tick = -1; second_tick = -1; last_tick = -1; found_at = -1;
    for (int i = 0; i < 60 && found_at < 0; i++) begin
      @(negedge clk);
      if (i > 0 && frame_tick) begin
        ticks++;
        last_tick = i;
        if (first_tick < 0) first_tick = i;
        else if (second_tick < 0) second_tick = i;
      end
      if (bdir && bc1) found_at = i;
    end
    chk("frame_ticks_before_addr", ticks, 3);
    chk("frame_addr_after_tick", found_at - last_tick, 2);
    chk("frame_tick_period", second_tick - first_tick, FRAME_DIV);
    next_cycle();
    wait_idle(60);

    // FIFO full: six commands offered on consecutive cycles, only four fit.
    seen_q.delete();
    for (int k = 0; k < 6; k++) begin
      cmd_valid = 1'b1; cmd_reg = 4'(k + 2); cmd_data = 8'(8'h10 + k); cmd_wait = 8'd2;
      @(negedge clk);
      if (cmd_ready) acc_regs.push_back(cmd_reg);
      @(posedge clk); #1;
    end
    nacc = acc_regs.size();
    chk("full_accept_count", nacc, 4);
    for (int k = 0; k < nacc; k++) chk($sformatf("full_accept_reg_%0d", k), acc_regs[k], k + 2);
    // Keep offering a seventh command: it must wait out the END pop cycle.
    cmd_reg = 4'hC; cmd_data = 8'h77; cmd_wait = 8'd2;
    accepted = 0; prev_pair = 2'b00; prev_ready = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        chk("pushpop_end_ready", {31'd0, prev_ready}, 32'd0);
        chk("pushpop_end_pair", {30'd0, prev_pair}, 32'd2);
        chk("pushpop_idle_pair", {30'd0, bdir, bc1}, 32'd0);
        accepted = 1;
      end
      prev_pair = {bdir, bc1}; prev_ready = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("pushpop_accepted", {31'd0, accepted}, 32'd1);
    wait_idle(200);
    chk("full_write_count", seen_q.size(), 5);
    if (seen_q.size() == 5) begin
      for (int k = 0; k < 4; k++) chk($sformatf("full_write_reg_%0d", k), seen_q[k], k + 2);
      chk("full_write_reg_4", seen_q[4], 32'hC);
    end

    // Flush during WRITE: current write finishes with full hold, second is dropped.
    seen_q.delete();
    push_cmd(4'h8, 8'h81, 8'd0);
    push_cmd(4'h9, 8'h91, 8'd0);
    wait_addr(20, seen);
    next_cycle();
    next_cycle();
    flush = 1'b1;
    n10 = 0; n11 = 0;
    @(negedge clk);
    if (bdir && !bc1) n10++;
    next_cycle();
    flush = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bdir && !bc1) n10++;
      if (bdir && bc1) n11++;
    end
    chk("flush_write_hold", n10, HOLD);
    chk("flush_write_no_more", n11, 0);
    chk("flush_write_busy", {31'd0, busy}, 32'd0);
    chk("flush_write_log", seen_q.size(), 1);
    next_cycle();

    // Flush during WAIT.
    push_cmd(4'h3, 8'h33, 8'd2);
    repeat (3) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_wait_busy", {31'd0, busy}, 32'd0);
    chk("flush_wait_pair", {30'd0, bdir, bc1}, 32'd0);
    n11 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bdir) n11++;
    end
    chk("flush_wait_no_write", n11, 0);
    next_cycle();

    // Asynchronous reset in the middle of the address phase.
    push_cmd(4'h5, 8'h55, 8'd0);
    wait_addr(20, seen);
    @(posedge clk); #1;
    chk("areset_pre_pair", {30'd0, bdir, bc1}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_pins", {22'd0, bdir, bc1, bus_data}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    n11 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bdir) n11++;
    end
    chk("areset_no_pending", n11, 0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_reg   = 4'($urandom_range(0, 15));
      cmd_data  = 8'($urandom_range(0, 255));
      cmd_wait  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
      flush     = ($urandom_range(0, 59) == 0);
      next_cycle();
    end
    cmd_valid = 1'b0;
    flush = 1'b0;
    wait_idle(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psg_write_scheduler.md
# psg_write_scheduler

Sequences timed register writes into the AY-3-8913 PSG core over its native BDIR/BC1 bus. A host pushes (register, data, frame-delay) commands into a small FIFO. The block waits the requested number of frame ticks, then issues a protocol-correct address-latch/data-write sequence. It sits between the host or playback logic and `tt_um_rejunity_ay8913`, and gives music playback frame-accurate register updates.

## Interface
- `DEPTH`, default 4: command FIFO entries; a power of two, minimum 2.
- `FRAME_DIV`, default 20000: clock cycles per frame tick; minimum 2.
- `HOLD`, default 2: cycles each active bus phase is held; minimum 1.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present on the `cmd_*` inputs.
- `cmd_ready` out 1: FIFO can accept; combinational, `!full && !flush`.
- `cmd_reg` in 4: PSG register address, R0–R15.
- `cmd_data` in 8: value to write.
- `cmd_wait` in 8: frame ticks to wait before issuing; 0 means immediate.
- `flush` in 1: discard all queued commands.
- `bus_data` out 8: data/address bus to the PSG; registered.
- `bdir` out 1: PSG BDIR; registered.
- `bc1` out 1: PSG BC1; registered.
- `frame_tick` out 1: one-cycle pulse per frame; registered.
- `busy` out 1: high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- **Frame counter:** free-running, 0..FRAME_DIV-1, then wraps to 0.
  - `frame_tick` is high for the cycle after the counter equals FRAME_DIV-1.
  - It runs regardless of FSM state.
- **FIFO:** stores {reg, wait, data}.
  - A push occurs on a clock edge with `cmd_valid && cmd_ready`.
  - A pop occurs when the FSM leaves END.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - When full, `cmd_ready=0` and pushes are ignored, not overwritten.
- **FSM states and transitions:**
  - IDLE → WAIT if the FIFO is non-empty and head.wait≠0. Load `wcnt` = head.wait.
  - IDLE → ADDR if the FIFO is non-empty and head.wait=0.
  - WAIT: decrement `wcnt` on each `frame_tick`. Go to ADDR on the tick that takes `wcnt` to 0.
  - A tick coinciding with WAIT entry is not counted.
  - ADDR (HOLD cycles): `bdir=1`, `bc1=1`, `bus_data={4'b0, head.reg}` (latch address).
  - GAP (1 cycle): `bdir=0`, `bc1=0`; `bus_data` holds its value.
  - WRITE (HOLD cycles): `bdir=1`, `bc1=0`, `bus_data=head.data`.
  - END (1 cycle): `bdir=0`, `bc1=0`. Pop the FIFO, then return to IDLE.
- **Bus rule:** `bdir`/`bc1` never go from 11 directly to 10. The pair 01 is never driven.
- **Flush:** takes effect on a clock edge with `flush=1`.
  - The FIFO empties and any push in that cycle is dropped.
  - In WAIT, the FSM goes to IDLE immediately.
  - In ADDR, GAP or WRITE, the current sequence completes through END, and the pop is suppressed because the FIFO is already empty.
  - In IDLE or END, no bus effect.
- **Reset mid-operation:** all state clears immediately (asynchronous). The bus goes to 00 and the queued command is lost.

## Timing
- **Reset values:**
  - `bdir=0`, `bc1=0`, `bus_data=0x00`, `frame_tick=0`, `busy=0`.
  - `cmd_ready=1` (FIFO empty, no flush).
  - Frame counter=0, FSM=IDLE.
- **Latency:** for a command accepted at edge T into an idle block with wait=0, `bdir=1`/`bc1=1` are visible from edge T+2.
- **Sequence length:** one write occupies 2·HOLD+2 cycles from ADDR entry to IDLE. With HOLD=2 that is 6 cycles.
- **Back-to-back commands:** with wait=0, consecutive sequences are separated by exactly 1 IDLE cycle, so the bus is 00 for 2 cycles (END + IDLE).
- **Frame wait:** ADDR begins on the cycle after the N-th `frame_tick` counted in WAIT. Jitter relative to the frame boundary is 0.
- **Wait of 0:** not equivalent to wait=1. Wait=1 aligns to the next frame tick.

## Test plan
- **Reset then single write.** HOLD=2; push reg=7, data=0x38, wait=0.
  - Response: bus 00, then 11 for 2 cycles with `bus_data`=0x07, then 00 for 1 cycle, then 10 for 2 cycles with `bus_data`=0x38, then 00.
  - `busy` falls after END.
- **Frame alignment.** FRAME_DIV=8; push wait=3 mid-frame.
  - Response: ADDR starts the cycle after the 3rd `frame_tick` following WAIT entry.
  - Check the distance between ticks is 8 cycles.
- **FIFO full.** DEPTH=4; hold `cmd_valid` high for 6 cmds with wait=2.
  - Response: `cmd_ready` drops after 4 accepts.
  - Exactly the accepted 4 are written in order, with no duplicates.
- **Simultaneous push/pop at full.** Push while END pops.
  - Response: `cmd_ready` stays 0 in that cycle, and the next cycle's `cmd_ready`=1.
  - Check the command count.
- **Flush during WRITE and WAIT.**
  - Flush during WRITE: the current write completes with the full HOLD, and no further writes occur.
  - Flush during WAIT: the bus stays 00, FSM=IDLE next cycle, and `busy`=0.
- **Async reset during ADDR.** Assert `rst_n`=0 mid-phase.
  - Response: `bdir`/`bc1`=0 without waiting for a clock edge.
  - After release, no pending write is issued.
